imm_packer: RTL
===============

# imm_packer

Narrows 8-bit signed values into the 6-bit or 4-bit immediate fields used by the instruction encoding. It is the encode-side counterpart of `signextender`: feeding `out_data`/`out_is_6bits` straight into `signextender` reproduces the original value whenever `out_ovf` is 0. It sits between the branch-offset/immediate generation logic and the instruction-word builder. It is a two-stage valid/ready pipeline with range checking, optional saturation and a sticky overflow counter.

## Interface
- `SATURATE`, default 1: 1 = clamp out-of-range values to the field min/max; 0 = truncate to the field's low bits.
- `clk` input 1: single clock, all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `in_valid` input 1: input value present.
- `in_ready` output 1: block can accept; a transfer occurs when `in_valid && in_ready` at a rising edge.
- `in_data` input 8: two's-complement value to pack.
- `in_want6` input 1: 1 = 6-bit field requested; 0 = 4-bit field.
- `out_valid` output 1: result present.
- `out_ready` input 1: consumer accepts; a transfer occurs when `out_valid && out_ready` at a rising edge.
- `out_data` output 6: packed field. In 4-bit mode, bits [5:4] are copies of bit 3.
- `out_is_6bits` output 1: echo of `in_want6`; connects to `signextender.is_6bits`.
- `out_ovf` output 1: value did not fit the requested field.
- `ovf_clear` input 1: synchronous clear of `ovf_count`.
- `ovf_count` output 8: number of overflowed results transferred out; saturates at 255.

## Operation
- Field ranges: 6-bit is -32..31; 4-bit is -8..7.
- Fit test (6-bit): `in_data[7:5]` are all equal.
- Fit test (4-bit): `in_data[7:3]` are all equal.
- Fit, 6-bit mode: `out_data = in_data[5:0]`, `out_ovf = 0`.
- Fit, 4-bit mode: `out_data = {in_data[3], in_data[3], in_data[3:0]}`, `out_ovf = 0`.
- No fit, `SATURATE=1`: the clamp direction follows `in_data[7]`.
  - 6-bit: positive gives 6'h1F, negative gives 6'h20.
  - 4-bit: positive gives 6'h07, negative gives 6'h38.
- No fit, `SATURATE=0`: the low bits are passed through exactly as in the fit case. `out_ovf = 1` in both modes.
- Stage A register: captures `in_data` and `in_want6`, and computes the fit flags.
- Stage B register: holds `out_data`, `out_is_6bits` and `out_ovf`.
  - Stage B loads when it is empty or being drained (`!out_valid || out_ready`).
  - Stage A loads when it is empty or moving into B.
- `in_ready = !a_valid || b_can_load`. This is combinational from `out_ready`; no other combinational paths exist from inputs to outputs.
- Ordering is strictly FIFO. No value is dropped or duplicated under any combination of stalls.
- `ovf_count` increments by 1 on each output transfer with `out_ovf=1`, and holds at 255.
  - `ovf_clear` has priority over a same-cycle increment: the result is 0.
  - `ovf_clear` does not affect pipeline data.

## Timing
- Reset values: `a_valid=0`, `out_valid=0`, `out_data=0`, `out_is_6bits=0`, `out_ovf=0`, `ovf_count=0`. `in_ready=1` once reset is deasserted.
- Reset asserted mid-transfer discards both stages at once; no partial output is produced.
- Latency: an input accepted at edge N gives `out_valid=1` after edge N+1 (presented during cycle N+1..N+2). With `out_ready` held high, the first transfer out happens at edge N+2.
- Throughput: 1 value per cycle with `out_ready` held high.
- Backpressure: with `out_ready` low, exactly 2 values are accepted and then `in_ready` falls.
  - When `out_ready` rises, `in_ready` rises in the same cycle (full-pipeline simultaneous in/out).
- Output stability: while `out_valid && !out_ready`, `out_data`, `out_is_6bits` and `out_ovf` are held unchanged.

## Test plan
- Reset then 6-bit in range: `in_data=8'hF0` (-16), `in_want6=1` -> `out_data=6'h30`, `out_is_6bits=1`, `out_ovf=0`, two edges after accept.
- 4-bit in range: `8'h05` gives `6'h05`, `ovf=0`; `8'hFA` (-6) gives `6'h3A`, `ovf=0`. Check both through `signextender`, which returns `8'h05` and `8'hFA`.
- Saturation (`SATURATE=1`):
  - `8'h40`, 6-bit -> `6'h1F`, `ovf=1`.
  - `8'h80`, 4-bit -> `6'h38`, `ovf=1`.
  - `ovf_count` goes 0 -> 2.
- Truncation (`SATURATE=0`): `8'h40`, 6-bit -> `6'h00`, `ovf=1`; `8'h13`, 4-bit -> `6'h03`, `ovf=1`.
- Backpressure: hold `out_ready=0` and stream 10,11,12.
  - `in_ready` drops after 2 accepts; the output holds 10 steady.
  - After releasing `out_ready`: outputs come out in order 10,11,12, with no loss.
- Counter edges:
  - 260 overflowed transfers -> `ovf_count=255`.
  - `ovf_clear` in the same cycle as an overflow transfer -> 0.
  - Asserting `reset` while 2 values are in flight -> `out_valid=0` immediately, and nothing is emitted after release.

Source files
------------

// File: rtl/imm_packer.sv
// Narrows 8-bit signed values into 6-bit or 4-bit immediate fields.
// Two-stage valid/ready pipeline with range check, optional clamp and a sticky overflow count.
module imm_packer #(
    parameter bit SATURATE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_want6,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_data,
    output logic       out_is_6bits,
    output logic       out_ovf,
    input  logic       ovf_clear,
    output logic [7:0] ovf_count
);

    typedef struct packed {
        logic [7:0] data;
        logic       want6;
        logic       fit6;
        logic       fit4;
    } stage_a_t;

    logic     a_valid;
    stage_a_t a_q;
    logic     b_can_load;
    logic     a_load;
    logic     fit;
    logic [5:0] trunc_field;
    logic [5:0] sat_field;
    logic [5:0] packed_field;

    assign b_can_load = !out_valid || out_ready;
    assign a_load     = !a_valid || b_can_load;
    assign in_ready   = a_load;

    // Stage A: capture the raw value and precompute both fit flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_valid <= 1'b0;
            a_q     <= '0;
        end else if (a_load) begin
            a_valid <= in_valid;
            if (in_valid) begin
                a_q.data  <= in_data;
                a_q.want6 <= in_want6;
                a_q.fit6  <= (&in_data[7:5]) | ~(|in_data[7:5]);
                a_q.fit4  <= (&in_data[7:3]) | ~(|in_data[7:3]);
            end
        end
    end

    always_comb begin
        fit          = a_q.want6 ? a_q.fit6 : a_q.fit4;
        trunc_field  = a_q.want6 ? a_q.data[5:0]
                                 : {a_q.data[3], a_q.data[3], a_q.data[3:0]};
        sat_field    = a_q.want6 ? (a_q.data[7] ? 6'h20 : 6'h1F)
                                 : (a_q.data[7] ? 6'h38 : 6'h07);
        packed_field = (fit || !SATURATE) ? trunc_field : sat_field;
    end

    // Stage B: output register, held while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_is_6bits <= 1'b0;
            out_ovf      <= 1'b0;
        end else if (b_can_load) begin
            out_valid <= a_valid;
            if (a_valid) begin
                out_data     <= packed_field;
                out_is_6bits <= a_q.want6;
                out_ovf      <= !fit;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_count <= '0;
        end else if (ovf_clear) begin
            ovf_count <= '0;
        end else if (out_valid && out_ready && out_ovf && (ovf_count != 8'hFF)) begin
            ovf_count <= ovf_count + 8'd1;
        end
    end

endmodule
